// File: rtl/pipe_pkg.sv
// Types and constants shared by the IF stage, ID stage and hazard unit.
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HELD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    function automatic logic [31:0] pc_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage with IF/ID register and one-entry skid buffer;
// single outstanding imem request, honours hazard-unit stall and redirect.
//
// state | meaning
// FETCH | issue a request at pc
// WAIT  | request outstanding
// HELD  | response parked in skid buffer, IF/ID stalled
// DRAIN | discard the stale response of a redirected fetch
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = pipe_pkg::DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = pipe_pkg::NOP_INSTR
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_pc_write,
    input  logic        i_if_id_write,
    input  logic        i_branch_taken,
    input  logic [31:0] i_bta,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_pc,
    output logic [31:0] o_if_id_pc,
    output logic [31:0] o_if_id_instr,
    output logic        o_if_id_valid,
    output logic [4:0]  o_if_id_rs,
    output logic [4:0]  o_if_id_rt,
    output logic [15:0] o_if_id_imm
);
    import pipe_pkg::*;

    fetch_state_e r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_if_id_pc;
    logic [31:0]  r_if_id_instr;
    logic         r_if_id_valid;
    logic [31:0]  r_skid_pc;
    logic [31:0]  r_skid_instr;

    fetch_state_e w_state_nxt;
    logic [31:0]  w_pc_nxt;
    logic [31:0]  w_if_id_pc_nxt;
    logic [31:0]  w_if_id_instr_nxt;
    logic         w_if_id_valid_nxt;
    logic [31:0]  w_skid_pc_nxt;
    logic [31:0]  w_skid_instr_nxt;
    logic         w_commit;
    logic         w_bubble;
    logic [31:0]  w_bta_aligned;

    assign w_commit      = i_pc_write && i_if_id_write;
    assign w_bta_aligned = pc_align(i_bta);

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_if_id_pc_nxt    = r_if_id_pc;
        w_if_id_instr_nxt = r_if_id_instr;
        w_if_id_valid_nxt = r_if_id_valid;
        w_skid_pc_nxt     = r_skid_pc;
        w_skid_instr_nxt  = r_skid_instr;
        w_bubble          = 1'b0;

        if (i_branch_taken) begin
            // Redirect wins over stall and over any response this cycle.
            w_pc_nxt          = w_bta_aligned;
            w_if_id_instr_nxt = NOP_INSTR;
            w_if_id_valid_nxt = 1'b0;
            w_skid_pc_nxt     = 32'h0;
            w_skid_instr_nxt  = 32'h0;
            if (((r_state == WAIT) || (r_state == DRAIN)) && !i_imem_rvalid)
                w_state_nxt = DRAIN;
            else
                w_state_nxt = FETCH;
        end else begin
            case (r_state)
                FETCH: begin
                    w_state_nxt = WAIT;
                    w_bubble    = i_if_id_write;
                end
                WAIT: begin
                    if (i_imem_rvalid) begin
                        if (w_commit) begin
                            w_if_id_instr_nxt = i_imem_rdata;
                            w_if_id_pc_nxt    = r_pc;
                            w_if_id_valid_nxt = 1'b1;
                            w_pc_nxt          = r_pc + PC_STEP;
                            w_state_nxt       = FETCH;
                        end else begin
                            w_skid_instr_nxt = i_imem_rdata;
                            w_skid_pc_nxt    = r_pc;
                            w_state_nxt      = HELD;
                            w_bubble         = i_if_id_write;
                        end
                    end else begin
                        w_bubble = i_if_id_write;
                    end
                end
                HELD: begin
                    if (w_commit) begin
                        w_if_id_instr_nxt = r_skid_instr;
                        w_if_id_pc_nxt    = r_skid_pc;
                        w_if_id_valid_nxt = 1'b1;
                        w_pc_nxt          = r_pc + PC_STEP;
                        w_skid_pc_nxt     = 32'h0;
                        w_skid_instr_nxt  = 32'h0;
                        w_state_nxt       = FETCH;
                    end else begin
                        // pc_write low with IF/ID open: keep the parked word, send a bubble
                        w_bubble = i_if_id_write;
                    end
                end
                DRAIN: begin
                    if (i_imem_rvalid)
                        w_state_nxt = FETCH;
                    w_bubble = i_if_id_write;
                end
                default: begin
                    w_state_nxt = FETCH;
                end
            endcase

            if (w_bubble) begin
                w_if_id_instr_nxt = NOP_INSTR;
                w_if_id_valid_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= FETCH;
            r_pc          <= RESET_PC;
            r_if_id_pc    <= 32'h0;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_valid <= 1'b0;
            r_skid_pc     <= 32'h0;
            r_skid_instr  <= 32'h0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_if_id_pc    <= w_if_id_pc_nxt;
            r_if_id_instr <= w_if_id_instr_nxt;
            r_if_id_valid <= w_if_id_valid_nxt;
            r_skid_pc     <= w_skid_pc_nxt;
            r_skid_instr  <= w_skid_instr_nxt;
        end
    end

    // Gated by reset so no request escapes while the state is forced to FETCH.
    assign o_imem_req    = i_rst_n && (r_state == FETCH) && !i_branch_taken;
    assign o_imem_addr   = r_pc;
    assign o_pc          = r_pc;
    assign o_if_id_pc    = r_if_id_pc;
    assign o_if_id_instr = r_if_id_instr;
    assign o_if_id_valid = r_if_id_valid;
    assign o_if_id_rs    = r_if_id_instr[RS_MSB:RS_LSB];
    assign o_if_id_rt    = r_if_id_instr[RT_MSB:RT_LSB];
    assign o_if_id_imm   = r_if_id_instr[IMM_MSB:IMM_LSB];

endmodule
